// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and round-robin pick helper for mux4_rr_arbiter
package arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    typedef logic [1:0] arb_src_t;

    // Walks from lowest to highest priority so the highest-priority valid index wins last.
    function automatic arb_src_t rr_pick(input logic [NUM_REQ-1:0] valid, input arb_src_t ptr);
        arb_src_t idx;
        arb_src_t pick;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + arb_src_t'(k);
            if (valid[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/MuxN_4_1.sv
// rtl/MuxN_4_1.sv - N-bit 4:1 data multiplexer
module MuxN_4_1 #(
    parameter int N = 8
) (
    input  logic [1:0]   sel,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic [N-1:0] in3,
    output logic [N-1:0] out
);

    always_comb begin
        case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in3;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin burst arbiter sharing one registered output channel
module mux4_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req_valid,
    input  logic [NUM_REQ-1:0]  req_last,
    input  logic [N-1:0]        req_data_0,
    input  logic [N-1:0]        req_data_1,
    input  logic [N-1:0]        req_data_2,
    input  logic [N-1:0]        req_data_3,
    output logic [NUM_REQ-1:0]  req_ready,
    output logic                out_valid,
    output logic [N-1:0]        out_data,
    output logic                out_last,
    output logic [1:0]          out_src,
    input  logic                out_ready
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

    arb_state_t      state_q, state_d;
    arb_src_t        ptr_q, ptr_d;
    arb_src_t        owner_q, owner_d;
    logic [CW-1:0]   count_q, count_d;
    logic            out_valid_q, out_valid_d;
    logic [N-1:0]    out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    arb_src_t        out_src_q, out_src_d;

    logic [N-1:0]    mux_data;
    logic            slot_free;
    logic            accept;
    logic            beat_last;

    MuxN_4_1 #(.N(N)) u_mux (
        .sel (owner_q),
        .in0 (req_data_0),
        .in1 (req_data_1),
        .in2 (req_data_2),
        .in3 (req_data_3),
        .out (mux_data)
    );

    // Ready depends only on registered state and out_ready, never on req_valid.
    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        req_ready = '0;
        if (state_q == ARB_BUSY) begin
            req_ready[owner_q] = slot_free;
        end
    end

    assign accept    = (state_q == ARB_BUSY) && req_valid[owner_q] && slot_free;
    assign beat_last = req_last[owner_q] || (count_q == LAST_CNT);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;

        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ARB_IDLE: begin
                if (|req_valid) begin
                    owner_d = rr_pick(req_valid, ptr_q);
                    count_d = '0;
                    state_d = ARB_BUSY;
                end
            end
            default: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mux_data;
                    out_src_d   = owner_q;
                    out_last_d  = beat_last;
                    count_d     = count_q + 1'b1;
                    if (beat_last) begin
                        ptr_d   = owner_q + 2'd1;
                        count_d = '0;
                        state_d = ARB_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid;
    logic [3:0] req_last;
    logic [7:0] req_data_0, req_data_1, req_data_2, req_data_3;
    logic [3:0] req_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic [1:0] out_src;
    logic       out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.N(8), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data_0 (req_data_0),
        .req_data_1 (req_data_1),
        .req_data_2 (req_data_2),
        .req_data_3 (req_data_3),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_src    (out_src),
        .out_ready  (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                             input logic l, input logic [1:0] s);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".last"},  32'(out_last),  32'(l));
        check({tag, ".src"},   32'(out_src),   32'(s));
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 4'b0000;
        req_last   = 4'b0000;
        req_data_0 = 8'h00;
        req_data_1 = 8'h00;
        req_data_2 = 8'h00;
        req_data_3 = 8'h00;
        out_ready  = 1'b1;
        step();
        step();
        settle();
        check_out("reset", 1'b0, 8'h00, 1'b0, 2'd0);
        check("reset.ready", 32'(req_ready), 32'h0);
        step();
        rst = 1'b0;

        // Single requester: req 2, three beats, last on the third
        req_valid  = 4'b0100;
        req_data_2 = 8'h21;
        settle();
        check("single.idle_ready", 32'(req_ready), 32'h0);
        step();
        settle();
        check("single.grant", 32'(req_ready), 32'b0100);
        step();
        req_data_2 = 8'h22;
        settle();
        check_out("single.b1", 1'b1, 8'h21, 1'b0, 2'd2);
        check("single.b1_ready", 32'(req_ready), 32'b0100);
        step();
        req_data_2 = 8'h23;
        req_last   = 4'b0100;
        settle();
        check_out("single.b2", 1'b1, 8'h22, 1'b0, 2'd2);
        step();
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        settle();
        check_out("single.b3", 1'b1, 8'h23, 1'b1, 2'd2);
        check("single.end_ready", 32'(req_ready), 32'h0);
        step();
        settle();
        check("single.drain", 32'(out_valid), 32'h0);

        // ptr is now 3: with req 0 and req 3 valid, req 3 must win
        step();
        req_valid = 4'b1001;
        req_last  = 4'b1001;
        step();
        settle();
        check("ptr3.grant", 32'(req_ready), 32'b1000);
        step();
        req_valid = 4'b0000;
        settle();
        check("ptr3.src", 32'(out_src), 32'd3);
        step();

        // Fairness: all valid, last on every beat, from ptr 0
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            settle();
            check($sformatf("fair.idle%0d", g), 32'(req_ready), 32'h0);
            if (g > 0) begin
                check($sformatf("fair.src%0d", g - 1), 32'(out_src), 32'((g - 1) % 4));
            end
            step();
            settle();
            check($sformatf("fair.grant%0d", g), 32'(req_ready), 32'(1 << (g % 4)));
            step();
        end
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        settle();
        check("fair.src4", 32'(out_src), 32'd0);
        step();

        // Forced rotation: req 1 never marks last, req 3 waiting; ptr is 1
        req_valid = 4'b1010;
        step();
        for (int b = 1; b <= 4; b++) begin
            req_data_1 = 8'(8'h30 + b);
            settle();
            check($sformatf("force.ready%0d", b), 32'(req_ready), 32'b0010);
            if (b > 1) begin
                check_out($sformatf("force.b%0d", b - 1), 1'b1, 8'(8'h30 + b - 1), 1'b0, 2'd1);
            end
            step();
        end
        req_last = 4'b1000;
        settle();
        check_out("force.b4", 1'b1, 8'h34, 1'b1, 2'd1);
        check("force.idle", 32'(req_ready), 32'h0);
        step();
        settle();
        check("force.next_grant", 32'(req_ready), 32'b1000);
        step();
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        step();

        // Backpressure: req 0 owner, stall three cycles holding 0xA5
        req_valid  = 4'b0001;
        req_data_0 = 8'hA5;
        step();
        settle();
        check("bp.grant", 32'(req_ready), 32'b0001);
        step();
        out_ready  = 1'b0;
        req_data_0 = 8'hB6;
        req_last   = 4'b0001;
        for (int s = 0; s < 3; s++) begin
            settle();
            check_out($sformatf("bp.stall%0d", s), 1'b1, 8'hA5, 1'b0, 2'd0);
            check($sformatf("bp.stall%0d.ready", s), 32'(req_ready), 32'h0);
            step();
        end
        out_ready = 1'b1;
        settle();
        check_out("bp.release", 1'b1, 8'hA5, 1'b0, 2'd0);
        check("bp.release.ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        settle();
        check_out("bp.b2", 1'b1, 8'hB6, 1'b1, 2'd0);
        step();

        // Owner gap: req 1 owns, drops valid for two cycles while req 0 waits
        req_valid  = 4'b0011;
        req_data_1 = 8'h41;
        step();
        settle();
        check("gap.grant", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b0001;
        settle();
        check_out("gap.b1", 1'b1, 8'h41, 1'b0, 2'd1);
        check("gap.hold0", 32'(req_ready), 32'b0010);
        step();
        settle();
        check("gap.hold1", 32'(req_ready), 32'b0010);
        check("gap.no_beat", 32'(out_valid), 32'h0);
        step();
        req_valid  = 4'b0011;
        req_data_1 = 8'h42;
        req_last   = 4'b0010;
        settle();
        check("gap.resume", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        settle();
        check_out("gap.b2", 1'b1, 8'h42, 1'b1, 2'd1);
        step();

        // Reset mid-burst: req 3 owns (ptr 2) with a beat buffered
        req_valid  = 4'b1000;
        req_data_3 = 8'h5A;
        step();
        step();
        rst = 1'b1;
        settle();
        check_out("rst.pre", 1'b1, 8'h5A, 1'b0, 2'd3);
        step();
        rst       = 1'b0;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        settle();
        check_out("rst.post", 1'b0, 8'h00, 1'b0, 2'd0);
        check("rst.ready", 32'(req_ready), 32'h0);
        step();
        settle();
        check("rst.ptr0_grant", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
